// File: rtl/i2s_deserializer.sv
// i2s_deserializer: mclk-oversampled I2S receiver that rebuilds {left,right} frames and tracks frame lock
module i2s_deserializer #(
  parameter int WORD_BITS   = 16,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  input  logic                   bck,
  input  logic                   wclk,
  input  logic                   sdata,
  output logic [2*WORD_BITS-1:0] data,
  output logic                   dtw,
  output logic                   locked,
  output logic                   err
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LF = GW'(LOCK_FRAMES);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);
  localparam logic [5:0] WB = 6'(WORD_BITS);
  typedef enum logic [1:0] {IDLE, ALIGN, LOCKED} state_t;
  state_t state;
  logic bck_s1, bck_s2, bck_s3, wclk_s1, wclk_s2, sdata_s1, sdata_s2;
  logic wclk_prev, left_ok, rise, bound, bad;
  logic [WORD_BITS-2:0] shift;
  logic [WORD_BITS-1:0] left, word;
  logic [4:0] cnt;
  logic [5:0] len;
  logic [GW-1:0] good;
  logic [TW-1:0] tmo;
  always_comb begin
    rise  = bck_s2 & ~bck_s3;
    bound = rise & (wclk_s2 != wclk_prev);
    word  = {shift, sdata_s2};
    len   = {1'b0, cnt} + 6'd1;
    bad   = (len != WB) | (wclk_prev & ~left_ok);
  end
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      {bck_s1, bck_s2, bck_s3, wclk_s1, wclk_s2, sdata_s1, sdata_s2} <= '0;
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      left      <= '0;
      left_ok   <= 1'b0;
      good      <= '0;
      tmo       <= '0;
      wclk_prev <= 1'b0;
      data      <= '0;
      dtw       <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      {bck_s3, bck_s2, bck_s1} <= {bck_s2, bck_s1, bck};
      {wclk_s2, wclk_s1}       <= {wclk_s1, wclk};
      {sdata_s2, sdata_s1}     <= {sdata_s1, sdata};
      dtw <= 1'b0;
      err <= 1'b0;
      if (rise) begin
        shift     <= word[WORD_BITS-2:0];
        cnt       <= bound ? 5'd0 : (&cnt ? cnt : cnt + 5'd1);
        wclk_prev <= wclk_s2;
        tmo       <= '0;
        if (bound) begin
          if (state == IDLE) begin
            state   <= ALIGN;
            left_ok <= 1'b0;
            good    <= '0;
          end else if (bad) begin
            err     <= 1'b1;
            good    <= '0;
            left_ok <= 1'b0;
            if (state == LOCKED) begin
              state  <= ALIGN;
              locked <= 1'b0;
            end
          end else if (!wclk_prev) begin
            left    <= word;
            left_ok <= 1'b1;
          end else begin
            left_ok <= 1'b0;
            good    <= (good == LF) ? good : good + 1'b1;
            if (state == LOCKED) begin
              data <= {left, word};
              dtw  <= 1'b1;
            end else if (good + 1'b1 == LF) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
      end else if (tmo != TO) begin
        tmo <= tmo + 1'b1;
        if (state != IDLE && tmo + 1'b1 == TO) begin
          state   <= IDLE;
          err     <= 1'b1;
          locked  <= 1'b0;
          cnt     <= '0;
          good    <= '0;
          left_ok <= 1'b0;
          tmo     <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_deserializer.sv
// tb_i2s_deserializer: random I2S frames vs a word-level reference model, scoreboard-checked on dtw
`timescale 1ns/1ps
module tb_i2s_deserializer;
  localparam real TP = 61.0;
  localparam real BH = 8.0 * TP;
  localparam int LOCK = 4;
  localparam int S_IDLE = 0, S_ALIGN = 1, S_LOCKED = 2;
  typedef struct {
    logic [31:0] d;
    realtime     t;
  } exp_t;
  logic mclk = 1'b0, rst_n = 1'b0, bck = 1'b0, wclk = 1'b0, sdata = 1'b0;
  logic [31:0] data;
  logic dtw, locked, err;
  exp_t sbq[$];
  exp_t e;
  realtime lat;
  bit bq[$];
  int errors = 0, checks = 0, err_seen = 0, err_exp = 0;
  int m_state = S_IDLE, m_good = 0;
  bit m_prev = 1'b0, m_left_ok = 1'b0;
  logic [15:0] m_left = '0;
  logic [31:0] m_data = '0;
  i2s_deserializer dut (
    .mclk(mclk), .rst_n(rst_n), .bck(bck), .wclk(wclk), .sdata(sdata),
    .data(data), .dtw(dtw), .locked(locked), .err(err)
  );
  always #(TP / 2.0) mclk = ~mclk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge mclk) begin
    if (rst_n) begin
      if (err) begin
        err_seen++;
        check("err_without_dtw", 32'(dtw), 32'd0);
      end
      if (dtw) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dtw_unexpected: got data %h with no frame expected", data);
        end else begin
          e = sbq.pop_front();
          check("frame_data", data, e.d);
          lat = $realtime - e.t;
          check("dtw_latency_in_range", 32'(lat > 2.0 * TP && lat < 4.5 * TP), 32'd1);
        end
      end
    end
  end
  task automatic model_bit(input bit w, input bit d);
    logic [15:0] wv;
    bq.push_back(d);
    if (w != m_prev) begin
      wv = '0;
      foreach (bq[i]) wv = {wv[14:0], bq[i]};
      if (m_state == S_IDLE) begin
        m_state = S_ALIGN;
      end else if (bq.size() != 16 || (m_prev && !m_left_ok)) begin
        err_exp++;
        m_good = 0;
        m_left_ok = 1'b0;
        if (m_state == S_LOCKED) m_state = S_ALIGN;
      end else if (!m_prev) begin
        m_left = wv;
        m_left_ok = 1'b1;
      end else begin
        m_left_ok = 1'b0;
        if (m_state == S_LOCKED) begin
          m_data = {m_left, wv};
          sbq.push_back('{m_data, $realtime});
        end else if (m_good + 1 >= LOCK) begin
          m_state = S_LOCKED;
        end
        if (m_good < LOCK) m_good++;
      end
      bq.delete();
    end
    m_prev = w;
  endtask
  task automatic model_timeout();
    if (m_state != S_IDLE) begin
      err_exp++;
      m_state = S_IDLE;
      m_good = 0;
      m_left_ok = 1'b0;
      bq.delete();
    end
  endtask
  task automatic model_reset();
    m_state = S_IDLE;
    m_good = 0;
    m_prev = 1'b0;
    m_left_ok = 1'b0;
    m_data = '0;
    bq.delete();
  endtask
  task automatic send_bit(input bit w, input bit d);
    wclk = w;
    sdata = d;
    #(BH) bck = 1'b1;
    model_bit(w, d);
    #(BH) bck = 1'b0;
  endtask
  task automatic send_word(input bit ch, input bit nch, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(i == 0 ? nch : ch, v[i]);
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, 1'b1, l, 16);
    send_word(1'b1, 1'b0, r, 16);
  endtask
  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_frame(16'($urandom), 16'($urandom));
  endtask
  task automatic checkpoint(input string name);
    check({name, "_locked"}, 32'(locked), 32'(m_state == S_LOCKED));
    check({name, "_err_count"}, err_seen, err_exp);
    check({name, "_data"}, data, m_data);
  endtask
  initial begin
    repeat (4) @(negedge mclk);
    check("reset_data", data, 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_dtw", 32'(dtw), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge mclk);
    for (int i = 0; i < 4; i++) send_frame(16'h1234, 16'hABCD);
    checkpoint("pre_lock");
    send_frame(16'h1234, 16'hABCD);
    checkpoint("lock_frame5");
    send_frame(16'h1234, 16'hABCD);
    checkpoint("first_output");
    send_word(1'b0, 1'b1, 16'($urandom), 15);
    send_word(1'b1, 1'b0, 16'($urandom), 16);
    checkpoint("short_word");
    send_random(5);
    checkpoint("relock_after_short");
    #(80.0 * TP);
    model_timeout();
    checkpoint("timeout");
    send_random(6);
    checkpoint("relock_after_timeout");
    for (int i = 0; i < 2; i++) begin
      send_frame(16'h8000, 16'h7FFF);
      checkpoint("pattern_8000_7fff");
      send_frame(16'hFFFF, 16'h0001);
      checkpoint("pattern_ffff_0001");
    end
    for (int k = 1; k <= 16; k++) begin
      #(k);
      send_frame(16'($urandom), 16'($urandom));
    end
    checkpoint("phase_sweep");
    send_word(1'b0, 1'b1, 16'($urandom), 16);
    for (int i = 15; i >= 8; i--) send_bit(1'b1, 1'($urandom));
    check("pending_before_reset", sbq.size(), 32'd0);
    @(negedge mclk);
    rst_n = 1'b0;
    @(negedge mclk);
    check("midframe_reset_data", data, 32'd0);
    check("midframe_reset_locked", 32'(locked), 32'd0);
    check("midframe_reset_dtw", 32'(dtw), 32'd0);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'b1, 1'($urandom));
    checkpoint("after_midframe_reset");
    send_random(6);
    checkpoint("relock_after_reset");
    repeat (10) @(negedge mclk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
